// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared types and sizing helpers for the round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int c_default_num_masters     = 4;
    localparam int c_default_watchdog_cycles = 1024;

    // The counter only has to reach WATCHDOG_CYCLES-1; keep at least one bit.
    function automatic int wd_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin pick: first set request bit at or
//               after the pointer, wrapping modulo NUM_MASTERS.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = c_default_num_masters,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_request,
    input  logic [IDX_W-1:0]       i_pointer,
    output logic                   o_found,
    output logic [IDX_W-1:0]       o_index
);

    logic [2*NUM_MASTERS-1:0] w_doubled;
    logic [NUM_MASTERS-1:0]   w_rotated;
    logic [IDX_W-1:0]         w_offset;
    logic [IDX_W:0]           w_sum;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_doubled = {i_request, i_request} >> i_pointer;
    assign w_rotated = w_doubled[NUM_MASTERS-1:0];

    always_comb begin
        o_found  = 1'b0;
        w_offset = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_rotated[i]) begin
                o_found  = 1'b1;
                w_offset = IDX_W'(i);
            end
        end
    end

    assign w_sum   = {1'b0, i_pointer} + {1'b0, w_offset};
    assign o_index = (w_sum >= (IDX_W+1)'(NUM_MASTERS))
                   ? IDX_W'(w_sum - (IDX_W+1)'(NUM_MASTERS))
                   : w_sum[IDX_W-1:0];

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Round-robin arbiter holding a one-hot grant across a framed
//               bus transaction. Optional watchdog: BUS_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = c_default_num_masters,
    parameter int WATCHDOG_CYCLES = c_default_watchdog_cycles
) (
    input  logic                           clock,
    input  logic                           n_reset,
    input  logic [NUM_MASTERS-1:0]         request,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    input  logic                           begin_transactionIN,
    input  logic                           end_transactionIN,
    input  logic                           errorIN,
    output logic                           bus_busy,
    output logic                           watchdog_errorOUT
);

    localparam int c_idx_w = $clog2(NUM_MASTERS);

    arb_state_e              r_state_q,    w_state_d;
    logic [NUM_MASTERS-1:0]  r_grant_q,    w_grant_d;
    logic [c_idx_w-1:0]      r_grant_id_q, w_grant_id_d;
    logic [c_idx_w-1:0]      r_ptr_q,      w_ptr_d;
    logic                    r_busy_q,     w_busy_d;

    logic                    w_pick_found;
    logic [c_idx_w-1:0]      w_pick_idx;
    logic [NUM_MASTERS-1:0]  w_onehot;
    logic [c_idx_w-1:0]      w_ptr_next;
    logic                    w_release_evt;
    logic                    w_wd_fire;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_idx_w)
    ) u_picker (
        .i_request (request),
        .i_pointer (r_ptr_q),
        .o_found   (w_pick_found),
        .o_index   (w_pick_idx)
    );

    assign w_onehot   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_ptr_next = (r_grant_id_q == c_idx_w'(NUM_MASTERS - 1))
                      ? '0 : r_grant_id_q + c_idx_w'(1);

    // Begin wins over a simultaneous request drop; begin+end is a complete transfer.
    always_comb begin
        w_release_evt = 1'b0;
        case (r_state_q)
            ST_GRANTED: w_release_evt = begin_transactionIN ? end_transactionIN
                                                            : !request[r_grant_id_q];
            ST_BUSY:    w_release_evt = end_transactionIN || errorIN;
            default:    w_release_evt = 1'b0;
        endcase
    end

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int c_wd_w = wd_cnt_width(WATCHDOG_CYCLES);

    logic [c_wd_w-1:0] r_wd_cnt_q, w_wd_cnt_d;
    logic              r_wd_err_q, w_wd_err_d;
    logic              w_wd_expire;

    assign w_wd_expire = ((r_state_q == ST_GRANTED) || (r_state_q == ST_BUSY))
                      && (r_wd_cnt_q == c_wd_w'(WATCHDOG_CYCLES - 1));
    assign w_wd_fire   = w_wd_expire && !w_release_evt;

    // Counter sits at zero outside an open grant, so entering GRANTED starts from 0.
    always_comb begin
        w_wd_cnt_d = '0;
        if ((r_state_q == ST_GRANTED) || (r_state_q == ST_BUSY)) begin
            w_wd_cnt_d = r_wd_cnt_q + c_wd_w'(1);
        end
        w_wd_err_d = w_wd_fire;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_wd_cnt_q <= '0;
            r_wd_err_q <= 1'b0;
        end else begin
            r_wd_cnt_q <= w_wd_cnt_d;
            r_wd_err_q <= w_wd_err_d;
        end
    end

    assign watchdog_errorOUT = r_wd_err_q;
`else
    logic w_unused_wd_cfg;

    assign w_unused_wd_cfg   = (WATCHDOG_CYCLES > 0);
    assign w_wd_fire         = 1'b0;
    assign watchdog_errorOUT = 1'b0;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_grant_d    = r_grant_q;
        w_grant_id_d = r_grant_id_q;
        w_ptr_d      = r_ptr_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_d    = ST_GRANTED;
                    w_grant_d    = w_onehot;
                    w_grant_id_d = w_pick_idx;
                end
            end
            ST_GRANTED: begin
                if (w_release_evt || w_wd_fire) begin
                    w_state_d = ST_RELEASE;
                    w_grant_d = '0;
                end else if (begin_transactionIN) begin
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_release_evt || w_wd_fire) begin
                    w_state_d = ST_RELEASE;
                    w_grant_d = '0;
                end
            end
            ST_RELEASE: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_ptr_d   = w_ptr_next;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
            end
        endcase
        w_busy_d = (w_state_d == ST_GRANTED) || (w_state_d == ST_BUSY);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state_q    <= ST_IDLE;
            r_grant_q    <= '0;
            r_grant_id_q <= '0;
            r_ptr_q      <= '0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_grant_q    <= w_grant_d;
            r_grant_id_q <= w_grant_id_d;
            r_ptr_q      <= w_ptr_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign grant    = r_grant_q;
    assign grant_id = r_grant_id_q;
    assign bus_busy = r_busy_q;

endmodule : bus_arbiter_rr
`default_nettype wire

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin arbiter for the shared single-master-at-a-time system bus. Collects `request` lines from bus masters (JTAG DMA, CPU, other DMA engines) and issues one-hot `grant`. Tracks bus transaction framing so a grant is held from `begin_transaction` until `end_transaction` or a bus error. Sits beside the bus interconnect; every master's `request`/`granted` pair connects here.

## Interface
- `NUM_MASTERS`, 4, number of requesters (2..8)
- `WATCHDOG_CYCLES`, 1024, cycles a grant may stay open before forced release (used only with watchdog compiled in)
- `clock`  in  1  system clock, all logic on rising edge
- `n_reset`  in  1  asynchronous active-low reset
- `request`  in  NUM_MASTERS  per-master bus request, level
- `grant`  out  NUM_MASTERS  one-hot grant, registered
- `grant_id`  out  $clog2(NUM_MASTERS)  index of current/last grantee
- `begin_transactionIN`  in  1  bus begin-transaction strobe
- `end_transactionIN`  in  1  bus end-transaction strobe
- `errorIN`  in  1  bus error strobe
- `bus_busy`  out  1  high in GRANTED or BUSY
- `watchdog_errorOUT`  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANTED (grant issued, waiting for begin), BUSY (transaction open), RELEASE (one dead cycle).
- Reset: state IDLE, `grant`=0, `grant_id`=0, `bus_busy`=0, `watchdog_errorOUT`=0, priority pointer=0, watchdog counter=0.
- IDLE: if any `request` bit set, pick the first set bit at or after the pointer, wrapping modulo NUM_MASTERS; load `grant`/`grant_id`; go GRANTED.
- GRANTED: `begin_transactionIN` -> BUSY. Grantee drops `request` before begin -> RELEASE. `request` of others ignored.
- BUSY: `end_transactionIN` or `errorIN` -> RELEASE. Grantee `request` level ignored.
- RELEASE: `grant`=0; pointer = `grant_id`+1 modulo NUM_MASTERS; next state IDLE.
- `begin_transactionIN` and `end_transactionIN` in the same GRANTED cycle: complete transaction, go directly to RELEASE.
- `errorIN` in GRANTED: ignored. `errorIN` in IDLE/RELEASE: ignored.
- Bus strobes in IDLE or RELEASE are ignored; no state change.
- Pointer wrap: grantee NUM_MASTERS-1 -> pointer 0.
- `grant_id` holds the last grantee through IDLE; it is valid with `grant` only.

## Timing
- Request seen in IDLE at edge t -> `grant` high after edge t+1 (1-cycle latency).
- End/error at edge t -> `grant` low after t+1 (RELEASE) -> IDLE at t+2 -> next grant visible after t+3 at earliest. Bus idle gap is therefore 2 cycles minimum.
- Continuous requests from all masters: grants rotate 0,1,2,3,0...; no master waits more than NUM_MASTERS-1 transactions.
- Assertion of `n_reset` low mid-transaction clears all outputs immediately (asynchronous); masters must abort.

## Configuration
- `BUS_ARB_WATCHDOG_EN` defined: counter cleared on entering GRANTED, increments each cycle in GRANTED/BUSY. On reaching WATCHDOG_CYCLES-1 without end/error, go to RELEASE and pulse `watchdog_errorOUT` for exactly one cycle, coincident with the RELEASE cycle.
- Not defined: no counter; `watchdog_errorOUT` tied 0; a stuck transaction holds the bus indefinitely.

## Structure
- Package `bus_arb_pkg`: state enum (IDLE, GRANTED, BUSY, RELEASE), default NUM_MASTERS, watchdog counter width $clog2(WATCHDOG_CYCLES).
- Sub-module `rr_priority_picker`: combinational; takes request vector and pointer, returns found flag and index. Implemented as a double-width rotate plus find-first. The FSM, registers and watchdog stay in the top module.

## Test plan
- Reset, `request`=4'b0100 at cycle 2 -> `grant`=4'b0100 and `grant_id`=2 from cycle 3. Begin at 5, end at 9 -> `grant`=0 from 10, pointer=3.
- `request`=4'b1111 held, each transaction begin+end in 3 cycles -> grant order 0,1,2,3,0. There are 2 idle cycles between grants.
- Pointer=3, `request`=4'b1001 -> grant 3. After release, same requests -> grant 0 (wrap).
- Grantee drops `request` in GRANTED before begin -> RELEASE next cycle, no bus activity, other requester granted 2 cycles later.
- `errorIN` in BUSY -> RELEASE. Also, `n_reset` pulsed low during BUSY -> `grant`=0 immediately, pointer=0.
- With `BUS_ARB_WATCHDOG_EN`, WATCHDOG_CYCLES=16: grant with begin but no end -> `watchdog_errorOUT` single pulse 16 cycles after grant and `grant` cleared. Without the macro: grant held for 100 cycles, pulse never seen.
